// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-side bus definitions: DMA FSM states, register addresses
// and the bus direction encoding.
package nes_bus_pkg;

    // CPU write to this address starts a sprite DMA transfer.
    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    // PPU OAMDATA: destination of every DMA write.
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    // bus_rw / cpu_rw encoding.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRd,
        StAlign,
        StRead,
        StWrite
    } dma_state_t;

endpackage

// File: rtl/nes_oam_dma_arbiter_if.sv
// CPU-side and system-side bus signals of the OAM DMA arbiter.
// slave: the arbiter's view; master: the surrounding CPU core + memory map.
interface nes_oam_dma_arbiter_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_rw;
    logic [7:0]  bus_din;
    logic        dma_busy;

    modport master (
        output cpu_addr, cpu_dout, cpu_rw, bus_din,
        input  cpu_rdy, bus_addr, bus_dout, bus_rw, dma_busy
    );

    modport slave (
        input  cpu_addr, cpu_dout, cpu_rw, bus_din,
        output cpu_rdy, bus_addr, bus_dout, bus_rw, dma_busy
    );

endinterface

// File: rtl/nes_oam_dma_arbiter.sv
// NES sprite DMA arbiter: owns the CPU-side system bus, passes the 6502
// through when idle and, after a write to the DMA register, halts the CPU
// and copies XFER_LEN bytes from page XX00 to OAMDATA, one bus cycle per ce.
module nes_oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR  = nes_bus_pkg::DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = nes_bus_pkg::OAM_DATA_ADDR,
    // Must be a power of two, at most 256 (idx is 8 bits and wraps in-page).
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic                        i_clk,
    input  logic                        i_b_rst,
    input  logic                        i_ce,
    nes_oam_dma_arbiter_if.slave        io_bus
);

    import nes_bus_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t  r_state, w_state_d;
    logic [7:0]  r_page,  w_page_d;
    logic [7:0]  r_idx,   w_idx_d;
    logic [7:0]  r_data,  w_data_d;
    // 0 marks a "get" cycle, the only cycle on which the DMA may read.
    logic        r_parity, w_parity_d;

    logic [15:0] w_bus_addr;
    logic [7:0]  w_bus_dout;
    logic        w_bus_rw;
    logic        w_dma_reg_wr;

    assign w_dma_reg_wr = i_ce && (io_bus.cpu_rw == RW_WRITE) &&
                          (io_bus.cpu_addr == DMA_REG_ADDR);

    // State and datapath registers; everything but reset is gated by ce.
    always_ff @(posedge i_clk) begin
        if (i_b_rst) begin
            r_state  <= StIdle;
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_data   <= 8'h00;
            r_parity <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_page   <= w_page_d;
            r_idx    <= w_idx_d;
            r_data   <= w_data_d;
            r_parity <= w_parity_d;
        end
    end

    // Next-state logic and system bus mux.
    always_comb begin
        w_state_d  = r_state;
        w_page_d   = r_page;
        w_idx_d    = r_idx;
        w_data_d   = r_data;
        w_parity_d = r_parity;
        w_bus_addr = io_bus.cpu_addr;
        w_bus_dout = io_bus.cpu_dout;
        w_bus_rw   = io_bus.cpu_rw;

        if (i_ce) begin
            w_parity_d = ~r_parity;
        end

        case (r_state)
            StIdle: begin
                if (w_dma_reg_wr) begin
                    w_page_d  = io_bus.cpu_dout;
                    w_idx_d   = 8'h00;
                    w_state_d = StWaitRd;
                end
            end
            StWaitRd: begin
                // The 6502 only honours RDY on reads, so writes keep flowing.
                if (w_dma_reg_wr) begin
                    w_page_d = io_bus.cpu_dout;
                end else if (i_ce && (io_bus.cpu_rw == RW_READ)) begin
                    // Halt cycle: start on a get cycle, else burn one to align.
                    w_state_d = r_parity ? StRead : StAlign;
                end
            end
            StAlign: begin
                w_bus_rw = RW_READ;
                if (i_ce) begin
                    w_state_d = StRead;
                end
            end
            StRead: begin
                w_bus_addr = {r_page, r_idx};
                w_bus_rw   = RW_READ;
                if (i_ce) begin
                    w_data_d  = io_bus.bus_din;
                    w_state_d = StWrite;
                end
            end
            StWrite: begin
                w_bus_addr = OAM_DATA_ADDR;
                w_bus_dout = r_data;
                w_bus_rw   = RW_WRITE;
                if (i_ce) begin
                    w_idx_d   = r_idx + 8'd1;
                    w_state_d = (r_idx == LAST_IDX) ? StIdle : StRead;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign io_bus.bus_addr = w_bus_addr;
    assign io_bus.bus_dout = w_bus_dout;
    assign io_bus.bus_rw   = w_bus_rw;
    assign io_bus.cpu_rdy  = (r_state == StIdle);
    assign io_bus.dma_busy = (r_state != StIdle);

endmodule

// File: tb/tb_nes_oam_dma_arbiter.sv
// Bench for nes_oam_dma_arbiter: a scripted 6502 plus random memory, with
// every bus cycle checked against the transfer sequence derived from the
// DMA rules (get/put cycles counted from reset, 256 read/write pairs).
module tb_nes_oam_dma_arbiter;

    logic clk = 1'b0;
    logic b_rst;
    logic ce;

    always #5 clk = ~clk;

    nes_oam_dma_arbiter_if bus_if ();

    nes_oam_dma_arbiter dut (
        .i_clk   (clk),
        .i_b_rst (b_rst),
        .i_ce    (ce),
        .io_bus  (bus_if)
    );

    logic [7:0] mem [0:65535];
    assign bus_if.bus_din = mem[bus_if.bus_addr];

    int vectors     = 0;
    int miscompares = 0;
    // Number of ce cycles since reset; even count = get cycle.
    int ce_count    = 0;

    task automatic drive(input logic c, input logic [15:0] a, input logic [7:0] d,
                         input logic rw);
        ce              = c;
        bus_if.cpu_addr = a;
        bus_if.cpu_dout = d;
        bus_if.cpu_rw   = rw;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ce && !b_rst) ce_count++;
    endtask

    task automatic do_reset();
        b_rst = 1'b1;
        drive(1'b1, 16'h0000, 8'h00, 1'b1);
        tick();
        b_rst    = 1'b0;
        ce_count = 0;
    endtask

    // CPU read cycles with the arbiter idle: must be a pure passthrough.
    task automatic idle_cycles(input int n);
        logic [15:0] a;
        for (int k = 0; k < n; k++) begin
            a = 16'h8000 | 16'($urandom_range(0, 16'h7fff));
            drive(1'b1, a, 8'h00, 1'b1);
            vectors++;
            if ({bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr} !==
                {1'b1, 1'b0, 1'b1, a}) begin
                miscompares++;
                $display("FAIL idle: got rdy/busy/rw/addr %b%b%b %h want 101 %h",
                         bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr, a);
            end
            tick();
        end
    endtask

    // One DMA transfer from trigger onward. retrig >= 0 makes the last stall
    // write a second DMA register write; gap_at inserts 3 ce=0 cycles before
    // write gap_at; abort_after > 0 returns right after that many writes.
    task automatic run_transfer(input logic [7:0] page, input int stalls, input int retrig,
                                input int gap_at, input int abort_after,
                                output int rdy_low, output logic align);
        logic [7:0]  src;
        logic [15:0] a;
        logic [7:0]  d;
        logic [15:0] halt_a;
        logic [15:0] ra;
        logic [7:0]  wd;
        rdy_low = 0;
        src     = page;

        drive(1'b1, 16'h4014, page, 1'b0);
        vectors++;
        if ({bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr, bus_if.bus_dout}
            !== {1'b1, 1'b0, 1'b0, 16'h4014, page}) begin
            miscompares++;
            $display("FAIL trigger: got %b%b%b %h %h want 100 4014 %h", bus_if.cpu_rdy,
                     bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr, bus_if.bus_dout, page);
        end
        tick();

        for (int s = 0; s < stalls; s++) begin
            if (s == stalls - 1 && retrig >= 0) begin
                a   = 16'h4014;
                d   = retrig[7:0];
                src = d;
            end else begin
                a = {8'h01, 8'($urandom)};
                d = 8'($urandom);
            end
            drive(1'b1, a, d, 1'b0);
            vectors++;
            if ({bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr,
                 bus_if.bus_dout} !== {1'b0, 1'b1, 1'b0, a, d}) begin
                miscompares++;
                $display("FAIL stall_write: got %b%b%b %h %h want 010 %h %h", bus_if.cpu_rdy,
                         bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr, bus_if.bus_dout, a, d);
            end
            if (bus_if.cpu_rdy === 1'b0) rdy_low++;
            tick();
        end

        halt_a = 16'h8000 | 16'($urandom_range(1, 16'h7fff));
        drive(1'b1, halt_a, 8'h00, 1'b1);
        vectors++;
        if ({bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr} !==
            {1'b0, 1'b1, 1'b1, halt_a}) begin
            miscompares++;
            $display("FAIL halt_read: got %b%b%b %h want 011 %h", bus_if.cpu_rdy,
                     bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr, halt_a);
        end
        if (bus_if.cpu_rdy === 1'b0) rdy_low++;
        tick();

        // The first DMA read must land on a get cycle.
        align = ce_count[0];
        if (align) begin
            drive(1'b1, halt_a, 8'h00, 1'b1);
            vectors++;
            if ({bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr} !==
                {1'b0, 1'b1, 1'b1, halt_a}) begin
                miscompares++;
                $display("FAIL align_read: got %b%b%b %h want 011 %h", bus_if.cpu_rdy,
                         bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr, halt_a);
            end
            if (bus_if.cpu_rdy === 1'b0) rdy_low++;
            tick();
        end

        for (int i = 0; i < 256; i++) begin
            ra = {src, i[7:0]};
            wd = mem[ra];
            drive(1'b1, halt_a, 8'h00, 1'b1);
            vectors++;
            if ({bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr} !==
                {1'b0, 1'b1, 1'b1, ra}) begin
                miscompares++;
                $display("FAIL dma_read[%0d]: got %b%b%b %h want 011 %h", i, bus_if.cpu_rdy,
                         bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr, ra);
            end
            if (bus_if.cpu_rdy === 1'b0) rdy_low++;
            tick();

            if (i == gap_at) begin
                for (int g = 0; g < 3; g++) begin
                    drive(1'b0, halt_a, 8'h00, 1'b1);
                    vectors++;
                    if ({bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr,
                         bus_if.bus_dout} !== {1'b0, 1'b1, 1'b0, 16'h2004, wd}) begin
                        miscompares++;
                        $display("FAIL ce_gap[%0d]: got %b%b%b %h %h want 010 2004 %h", g,
                                 bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw,
                                 bus_if.bus_addr, bus_if.bus_dout, wd);
                    end
                    tick();
                end
            end

            drive(1'b1, halt_a, 8'h00, 1'b1);
            vectors++;
            if ({bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr,
                 bus_if.bus_dout} !== {1'b0, 1'b1, 1'b0, 16'h2004, wd}) begin
                miscompares++;
                $display("FAIL dma_write[%0d]: got %b%b%b %h %h want 010 2004 %h", i,
                         bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr,
                         bus_if.bus_dout, wd);
            end
            if (bus_if.cpu_rdy === 1'b0) rdy_low++;
            tick();
            if (i + 1 == abort_after) return;
        end
    endtask

    task automatic test_reset();
        logic [15:0] a;
        logic [7:0]  d;
        do_reset();
        a = 16'($urandom);
        drive(1'b1, a, 8'h5a, 1'b1);
        vectors++;
        if ({bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr,
             bus_if.bus_dout} !== {1'b1, 1'b0, 1'b1, a, 8'h5a}) begin
            miscompares++;
            $display("FAIL reset_state: got %b%b%b %h %h want 101 %h 5a", bus_if.cpu_rdy,
                     bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr, bus_if.bus_dout, a);
        end
        tick();
        // A write to a neighbouring register must not trigger.
        d = 8'($urandom);
        drive(1'b1, 16'h4015, d, 1'b0);
        vectors++;
        if ({bus_if.bus_rw, bus_if.bus_addr, bus_if.bus_dout} !== {1'b0, 16'h4015, d}) begin
            miscompares++;
            $display("FAIL write_passthru: got %b %h %h want 0 4015 %h", bus_if.bus_rw,
                     bus_if.bus_addr, bus_if.bus_dout, d);
        end
        tick();
        drive(1'b1, 16'h8000, 8'h00, 1'b1);
        vectors++;
        if ({bus_if.cpu_rdy, bus_if.dma_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL no_false_trigger: got rdy/busy %b%b want 10", bus_if.cpu_rdy,
                     bus_if.dma_busy);
        end
        tick();
    endtask

    // Reset, n idle cycles, one transfer, then RDY-low total and idle checks.
    task automatic test_transfer(input string name, input int pre, input logic [7:0] page,
                                 input int stalls, input int retrig, input int gap_at,
                                 input int exp_low);
        int   low;
        logic al;
        do_reset();
        idle_cycles(pre);
        run_transfer(page, stalls, retrig, gap_at, 0, low, al);
        vectors++;
        if (low !== exp_low) begin
            miscompares++;
            $display("FAIL %s rdy_low_cycles: got %0d want %0d", name, low, exp_low);
        end
        // After the last write (incl. page $FF wrap) the CPU address passes through.
        idle_cycles(2);
    endtask

    task automatic test_reset_abort();
        int          low;
        logic        al;
        logic [15:0] a;
        do_reset();
        idle_cycles(2);
        run_transfer(8'h40, 0, -1, -1, 100, low, al);
        b_rst = 1'b1;
        drive(1'b1, 16'h9000, 8'h00, 1'b1);
        tick();
        b_rst    = 1'b0;
        ce_count = 0;
        for (int k = 0; k < 8; k++) begin
            a = 16'h8000 | 16'($urandom_range(0, 16'h7fff));
            drive(1'b1, a, 8'h00, 1'b1);
            vectors++;
            if ({bus_if.cpu_rdy, bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr} !==
                {1'b1, 1'b0, 1'b1, a}) begin
                miscompares++;
                $display("FAIL reset_abort[%0d]: got %b%b%b %h want 101 %h", k, bus_if.cpu_rdy,
                         bus_if.dma_busy, bus_if.bus_rw, bus_if.bus_addr, a);
            end
            tick();
        end
    endtask

    // Back-to-back transfers without reset: random gaps, pages and stalls.
    task automatic test_back_to_back();
        int   low;
        int   st;
        logic al;
        do_reset();
        for (int t = 0; t < 3; t++) begin
            idle_cycles($urandom_range(0, 3));
            st = $urandom_range(0, 2);
            run_transfer(8'($urandom), st, -1, -1, 0, low, al);
            vectors++;
            if (low !== 513 + st + int'(al)) begin
                miscompares++;
                $display("FAIL b2b[%0d] rdy_low_cycles: got %0d want %0d", t, low,
                         513 + st + int'(al));
            end
        end
        idle_cycles(1);
    endtask

    initial begin
        b_rst = 1'b0;
        ce    = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_transfer("aligned",  2, 8'h02, 0, -1, -1, 513);
        test_transfer("odd_align", 3, 8'h02, 0, -1, -1, 514);
        test_transfer("write_stall", 2, 8'h02, 2, -1, -1, 515);
        test_transfer("retrigger", 2, 8'h03, 1, 5, -1, 515);
        test_transfer("page_wrap_gap", 2, 8'hff, 0, -1, 100, 513);
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nes_oam_dma_arbiter.md
Name: nes_oam_dma_arbiter

Overview:
- Owns the NES CPU-side system bus and arbitrates it between the 6502 core and the sprite (OAM) DMA engine.
- A CPU write to $4014 starts a transfer: the CPU is halted via RDY, then 256 bytes are copied from page XX00-XXFF to PPU OAMDATA ($2004).
- Sits between the CPU core's bus outputs and the system bus decoder/memory map.
- One bus cycle per `ce` pulse.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address of every DMA write.
- XFER_LEN, 256, bytes per transfer; must be a power of two, at most 256.

Ports:
- clk  in  1  system clock.
- b_rst  in  1  synchronous, active-high reset (1 = reset).
- ce  in  1  CPU cycle enable; all state advances only when ce=1.
- cpu_addr  in  16  CPU bus address.
- cpu_dout  in  8  CPU write data.
- cpu_rw  in  1  CPU direction: 1 = read, 0 = write.
- cpu_rdy  out  1  RDY to CPU; 0 = halt.
- bus_addr  out  16  system bus address.
- bus_dout  out  8  system bus write data.
- bus_rw  out  1  system bus direction: 1 = read, 0 = write.
- bus_din  in  8  system bus read data.
- dma_busy  out  1  high from the cycle after the trigger through the last DMA write.

Behaviour:
- State enum: IDLE, WAIT_RD, ALIGN, READ, WRITE.
- Registers: state, page[7:0], idx[7:0], data[7:0], parity.
  - parity toggles on every ce; parity=0 marks a "get" (read-eligible) cycle.
- Reset: state=IDLE, page=0, idx=0, data=0, parity=0.
  - Outputs at reset: cpu_rdy=1, dma_busy=0, bus passthrough.
  - Reset mid-transfer aborts immediately; no OAM writes after the reset cycle.
- IDLE:
  - Bus is a combinational passthrough of the CPU (bus_addr=cpu_addr, bus_dout=cpu_dout, bus_rw=cpu_rw); cpu_rdy=1.
  - When ce & !cpu_rw & cpu_addr==DMA_REG_ADDR: page<=cpu_dout, idx<=0, go to WAIT_RD.
  - The trigger write itself also passes to the bus.
- WAIT_RD (cpu_rdy=0, bus=passthrough):
  - The 6502 ignores RDY on write cycles, so the state holds while cpu_rw=0.
  - A further $4014 write here re-latches page (last write wins).
  - On ce & cpu_rw=1 (this is the halt cycle; the CPU repeats this read later):
    - if next-cycle parity==0, go to READ;
    - otherwise go to ALIGN.
- ALIGN (cpu_rdy=0):
  - Dummy read: bus_addr=cpu_addr, bus_rw=1.
  - Next state is READ.
- READ (cpu_rdy=0):
  - bus_addr={page,idx}, bus_rw=1.
  - At ce: data<=bus_din, go to WRITE.
- WRITE (cpu_rdy=0):
  - bus_addr=OAM_DATA_ADDR, bus_dout=data, bus_rw=0.
  - At ce: idx<=idx+1 (wraps 8-bit).
  - If idx==XFER_LEN-1, go to IDLE; otherwise go to READ.
- cpu_rdy is combinational from state: 1 only in IDLE.
- dma_busy = (state != IDLE).
- Total RDY-low cycles:
  - 513 if no alignment is needed, 514 with ALIGN;
  - plus one per CPU write cycle spent in WAIT_RD.
- Page $FF: source wraps within the page (idx 8-bit); no carry into page.
- With ce=0, state and all registers hold; outputs stay stable.

Decomposition:
- Shared package nes_bus_pkg:
  - dma_state_t enum;
  - address constants DMA_REG_ADDR, OAM_DATA_ADDR;
  - bus_rw encoding constants READ=1, WRITE=0.
- No sub-module; the parity flop, counter and mux belong in one module of ~150-200 lines.

Test Plan:
- Trigger with aligned parity: reset, then 2 ce cycles, then write $4014=$02 with next cycle cpu_rw=1.
  - Expect 256 read/write pairs, with reads at $0200..$02FF and writes to $2004 with matching data.
  - cpu_rdy low for exactly 513 ce cycles; dma_busy low afterwards.
- Odd alignment: same trigger shifted by one ce cycle.
  - Expect one ALIGN dummy read at cpu_addr and 514 RDY-low cycles.
- Write stalling: the two cycles after the trigger have cpu_rw=0 (stack pushes).
  - Both pass to the bus unmodified while RDY=0; DMA starts after the first read; 515 or 516 RDY-low cycles.
- Re-trigger in WAIT_RD: write $4014=$03 then $4014=$05 before any CPU read.
  - Source page is $05.
- Page wrap and ce gating: page $FF, with ce deasserted for 3 cycles mid-transfer.
  - Last read is $FFFF and the next address is not $0000.
  - Outputs and idx frozen during ce=0.
- Reset mid-transfer: assert b_rst after the 100th write.
  - Next cycle: cpu_rdy=1, dma_busy=0, bus passthrough, no further $2004 writes.
